// File: rtl/ncc_peak_finder.sv
// ncc_peak_finder: tracks the maximum signed NCC score and its (x,y) offset
// over one raster-ordered search window and reports it once per search.
module ncc_peak_finder #(
  parameter  int unsigned SCORE_W = 8,
  parameter  int unsigned COLS    = 64,
  parameter  int unsigned ROWS    = 64,
  localparam int unsigned XW      = $clog2(COLS),
  localparam int unsigned YW      = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               score_valid,
  output logic               score_ready,
  input  logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               peak_valid,
  output logic [SCORE_W-1:0] peak_score,
  output logic [XW-1:0]      peak_x,
  output logic [YW-1:0]      peak_y
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  logic [1:0]         state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [SCORE_W-1:0] max_q, max_d;
  logic [XW-1:0]      max_x_q, max_x_d;
  logic [YW-1:0]      max_y_q, max_y_d;
  logic               first_q, first_d;
  logic               last_xfer_c;

  logic               ready_q, busy_q, peak_valid_q;
  logic [SCORE_W-1:0] peak_score_q;
  logic [XW-1:0]      peak_x_q;
  logic [YW-1:0]      peak_y_q;

  // Next-state: search control, raster counters and running maximum.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    max_d       = max_q;
    max_x_d     = max_x_q;
    max_y_d     = max_y_q;
    first_d     = first_q;
    last_xfer_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          x_d     = '0;
          y_d     = '0;
          max_d   = '0;
          max_x_d = '0;
          max_y_d = '0;
          first_d = 1'b1;
        end
      end
      S_SCAN: begin
        if (start) begin
          // Restart wins over any coincident transfer.
          x_d     = '0;
          y_d     = '0;
          max_d   = '0;
          max_x_d = '0;
          max_y_d = '0;
          first_d = 1'b1;
        end else if (score_valid) begin
          // Strictly greater keeps the earliest raster position on ties.
          if (first_q || ($signed(score) > $signed(max_q))) begin
            max_d   = score;
            max_x_d = x_q;
            max_y_d = y_q;
          end
          first_d = 1'b0;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d         = '0;
              state_d     = S_DONE;
              last_xfer_c = 1'b1;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Search state, counters and running maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      max_q   <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      max_q   <= max_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
      first_q <= first_d;
    end
  end

  // Registered outputs; the peak is captured on the last transfer so it
  // appears together with peak_valid in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_score_q <= '0;
      peak_x_q     <= '0;
      peak_y_q     <= '0;
    end else begin
      ready_q      <= (state_d == S_SCAN);
      busy_q       <= (state_d == S_SCAN);
      peak_valid_q <= last_xfer_c;
      if (last_xfer_c) begin
        peak_score_q <= max_d;
        peak_x_q     <= max_x_d;
        peak_y_q     <= max_y_d;
      end
    end
  end

  assign score_ready = ready_q;
  assign busy        = busy_q;
  assign peak_valid  = peak_valid_q;
  assign peak_score  = peak_score_q;
  assign peak_x      = peak_x_q;
  assign peak_y      = peak_y_q;

endmodule
